key_debouncer: RTL and testbench



---
 rtl/key_debouncer_pkg.sv | 9 +
 rtl/key_debouncer_bit.sv | 67 ++++++
 rtl/key_debouncer.sv | 32 +++
 tb/tb_key_debouncer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// Board-level timing constants shared by the pushbutton conditioning logic.
package key_debouncer_pkg;

    localparam int CLOCK_FREQ_HZ      = 50_000_000;
    localparam int DEBOUNCE_TIME_MS   = 20;
    localparam int DEBOUNCE_CYCLES_20MS = CLOCK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;
    localparam int DEBOUNCE_COUNTER_WIDTH = 20;

endpackage

// File: rtl/key_debouncer_bit.sv
// Single-key conditioner: two-flop synchroniser, stability counter, debounced
// level and registered press/release strobes.
module key_debouncer_bit
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
    parameter int COUNTER_WIDTH   = DEBOUNCE_COUNTER_WIDTH
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                     sync1;
    logic                     sync2;
    logic                     sample;
    logic                     stable;
    logic                     accept;
    logic [COUNTER_WIDTH-1:0] count;

    assign sample  = ~sync2;
    assign accept  = (sample != stable) && (count == LAST_COUNT);
    assign pressed = stable;

    // Synchroniser resets to the released level so a held key is never seen during reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sample == stable) begin
            count <= '0;
        end else if (accept) begin
            stable <= sample;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Strobes are registered on the same edge that updates stable.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= accept &  sample;
            release_pulse <= accept & ~sample;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Debounces WIDTH independent active-low pushbuttons into active-high levels
// and single-cycle press/release strobes.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
    parameter int COUNTER_WIDTH   = DEBOUNCE_COUNTER_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debouncer_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .COUNTER_WIDTH   (COUNTER_WIDTH)
        ) u_bit (
            .clock         (clock),
            .resetn        (resetn),
            .key_n         (key_n[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_key_debouncer;

    localparam int WIDTH = 4;

    logic             clock;
    logic             resetn;
    logic [WIDTH-1:0] key_n;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    int n_compared   = 0;
    int n_mismatched = 0;

    key_debouncer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .COUNTER_WIDTH   (3)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] exp_pressed,
                                 input logic [3:0] exp_press, input logic [3:0] exp_release);
        check({tag, ".pressed"}, 32'(pressed), 32'(exp_pressed));
        check({tag, ".press_pulse"}, 32'(press_pulse), 32'(exp_press));
        check({tag, ".release_pulse"}, 32'(release_pulse), 32'(exp_release));
    endtask

    // Advance one rising edge, then park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Apply a held key pattern and verify the 6-edge qualification.
    task automatic settle(input string tag, input logic [3:0] new_key_n,
                          input logic [3:0] old_pressed, input logic [3:0] new_pressed,
                          input logic [3:0] exp_press, input logic [3:0] exp_release);
        key_n = new_key_n;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outputs($sformatf("%s.E%0d", tag, e), old_pressed, 4'b0000, 4'b0000);
        end
        step();
        check_outputs({tag, ".E6"}, new_pressed, exp_press, exp_release);
        step();
        check_outputs({tag, ".E7"}, new_pressed, 4'b0000, 4'b0000);
    endtask

    initial begin
        // 1: reset with all keys held down
        resetn = 1'b0;
        key_n  = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_outputs($sformatf("reset.c%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end

        // 2: release reset with all keys up, then press key 0
        key_n  = 4'b1111;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_outputs($sformatf("idle.c%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end
        settle("press0", 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        // 3: key 1 bounces 3 low / 1 high five times, never accepted
        for (int r = 0; r < 5; r++) begin
            key_n = 4'b1100;
            for (int c = 0; c < 3; c++) begin
                step();
                check_outputs($sformatf("bounce.r%0d.lo%0d", r, c), 4'b0001, 4'b0000, 4'b0000);
            end
            key_n = 4'b1110;
            step();
            check_outputs($sformatf("bounce.r%0d.hi", r), 4'b0001, 4'b0000, 4'b0000);
        end
        settle("press1", 4'b1100, 4'b0001, 4'b0011, 4'b0010, 4'b0000);

        // 4: release key 0
        settle("release0", 4'b1101, 4'b0011, 4'b0010, 4'b0000, 4'b0001);

        // 5: keys 3 and 2 pressed together, then held with no repeat strobes
        settle("press32", 4'b0001, 4'b0010, 4'b1110, 4'b1100, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step();
            check_outputs($sformatf("held.c%0d", c), 4'b1110, 4'b0000, 4'b0000);
        end

        // 6a: asynchronous reset clears pressed keys mid-cycle, no release strobe follows
        key_n = 4'b1111;
        #2 resetn = 1'b0;
        #1 check_outputs("async_rst", 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outputs($sformatf("post_rst.c%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end

        // 6b: reset pulse after E4 of a press discards the partial count
        key_n = 4'b1110;
        for (int e = 1; e <= 3; e++) begin
            step();
            check_outputs($sformatf("pre_rst.E%0d", e), 4'b0000, 4'b0000, 4'b0000);
        end
        @(posedge clock);
        #1 resetn = 1'b0;
        #3 check_outputs("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        #1 resetn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outputs($sformatf("requal.E%0d", e), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_outputs("requal.E6", 4'b0001, 4'b0001, 4'b0000);
        step();
        check_outputs("requal.E7", 4'b0001, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
